// File: rtl/irq_ctrl.sv
// -----------------------------------------------------------------------------
// irq_ctrl -- interrupt controller between peripheral IRQ lines and CPU HWInt.
//
// Latches, masks and prioritises up to NSRC (1..6) interrupt sources. The block
// sits behind the bus bridge as four word registers selected by Addr[3:2]:
//   0 MASK  RW [5:0]  1 = source enabled
//   1 PEND  R  [5:0]  write 1 clears that bit (edge sources only)
//   2 MODE  RW [5:0]  0 = edge, 1 = level
//   3 CUR   R  {valid, 28'b0, id[2:0]} of the highest-priority (lowest index)
//              pending and enabled source
// Pending edge sources are also cleared by int_ack for the current source.
//
// Ports:
//   clk      system clock, rising edge
//   reset    asynchronous reset, active low
//   Addr     word address [31:2] from the bridge, only [3:2] decoded
//   WE       register write enable (already decoded by the bridge)
//   Din      write data
//   Dout     read data, combinational from Addr[3:2]
//   src      raw interrupt requests (0 = Timer0, 1 = Timer1, 2 = external)
//   int_ack  one-cycle acknowledge from the CPU for the current interrupt
//   HWInt    PEND & MASK, to CPU HWInt[15:10]
//   irq      |HWInt
//
// Optional feature: define IRQC_SYNC_EN to pass src through a 2-flop
// synchronizer (adds two edges of latency). Without it src is used directly,
// which suits sources already synchronous to clk.
// -----------------------------------------------------------------------------
module irq_ctrl #(
  parameter int NSRC = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:2] Addr,
  input  logic        WE,
  input  logic [31:0] Din,
  output logic [31:0] Dout,
  input  logic [5:0]  src,
  input  logic        int_ack,
  output logic [5:0]  HWInt,
  output logic        irq
);

  typedef enum logic [1:0] {
    REG_MASK = 2'd0,
    REG_PEND = 2'd1,
    REG_MODE = 2'd2,
    REG_CUR  = 2'd3
  } reg_sel_e;

  // One bit per present source; bits from NSRC upward read 0 and drop writes.
  localparam logic [5:0] IMPL = 6'((1 << NSRC) - 1);

  reg_sel_e   sel;
  logic [5:0] src_s;
  logic [5:0] mask_q, mask_d;
  logic [5:0] pend_q, pend_d;
  logic [5:0] mode_q, mode_d;
  logic [5:0] src_prev_q, src_prev_d;
  logic       cur_valid;
  logic [2:0] cur_id;
  logic [5:0] active;
  logic [5:0] rise;
  logic [5:0] w1c;
  logic [5:0] ack_clr;
  logic [5:0] edge_next;

  assign sel = reg_sel_e'(Addr[3:2]);

`ifdef IRQC_SYNC_EN
  logic [5:0] sync1_q, sync1_d;
  logic [5:0] sync2_q, sync2_d;

  assign sync1_d = src;
  assign sync2_d = sync1_q;
  assign src_s   = sync2_q & IMPL;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end
`else
  assign src_s = src & IMPL;
`endif

  // Priority: the lowest-index pending and enabled source wins. Scanning from
  // the top down lets the last hit (the lowest index) overwrite earlier ones.
  assign active = pend_q & mask_q;

  always_comb begin
    // NOTE: every variable gets a default before any conditional assignment so
    // no path leaves it unassigned, which would infer a latch.
    cur_valid = 1'b0;
    cur_id    = 3'd0;
    for (int i = 5; i >= 0; i--) begin
      if (active[i]) begin
        cur_valid = 1'b1;
        cur_id    = 3'(i);
      end
    end
  end

  always_comb begin
    ack_clr = '0;
    if (int_ack && cur_valid) ack_clr[cur_id] = 1'b1;

    rise = src_s & ~src_prev_q;
    w1c  = (WE && sel == REG_PEND) ? Din[5:0] : 6'd0;

    // A new edge wins over any clear of the same bit in the same cycle.
    edge_next = rise | (pend_q & ~(w1c | ack_clr));

    // Level sources simply mirror the sampled input; clears do not apply.
    pend_d = ((mode_q & src_s) | (~mode_q & edge_next)) & IMPL;

    mask_d     = (WE && sel == REG_MASK) ? (Din[5:0] & IMPL) : mask_q;
    mode_d     = (WE && sel == REG_MODE) ? (Din[5:0] & IMPL) : mode_q;
    src_prev_d = src_s;
  end

  // NOTE: src_prev resets to 0, so a source already high when reset releases
  // is seen as a rising edge at the first clock.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mask_q     <= '0;
      pend_q     <= '0;
      mode_q     <= '0;
      src_prev_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge
      // values computed above, independent of statement order.
      mask_q     <= mask_d;
      pend_q     <= pend_d;
      mode_q     <= mode_d;
      src_prev_q <= src_prev_d;
    end
  end

  assign HWInt = active;
  assign irq   = |active;

  always_comb begin
    Dout = 32'd0;
    unique case (sel)
      REG_MASK: Dout = {26'd0, mask_q};
      REG_PEND: Dout = {26'd0, pend_q};
      REG_MODE: Dout = {26'd0, mode_q};
      REG_CUR:  Dout = {cur_valid, 28'd0, cur_id};
      default:  Dout = 32'd0;
    endcase
  end

  // Address and data bits that the register map never looks at.
  logic unused_bits;
  assign unused_bits = ^{Addr[31:4], Din[31:6]};

endmodule

// File: tb/tb_irq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_irq_ctrl -- self-checking bench for irq_ctrl.
// Directed steps for reset, edge latch, priority/ack, level mode, collisions
// and reset behaviour, followed by randomized traffic compared against a
// per-source behavioural model of the register rules.
// -----------------------------------------------------------------------------
module tb_irq_ctrl;

  localparam int NSRC = 6;
`ifdef IRQC_SYNC_EN
  localparam bit SYNC = 1'b1;
`else
  localparam bit SYNC = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [31:2] addr;
  logic        we;
  logic [31:0] din;
  logic [31:0] dout;
  logic [5:0]  src;
  logic        int_ack;
  logic [5:0]  hwint;
  logic        irq;

  int tests_run    = 0;
  int tests_failed = 0;

  irq_ctrl #(.NSRC(NSRC)) dut (
    .clk     (clk),
    .reset   (reset),
    .Addr    (addr),
    .WE      (we),
    .Din     (din),
    .Dout    (dout),
    .src     (src),
    .int_ack (int_ack),
    .HWInt   (hwint),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  bit [5:0] m_mask, m_pend, m_mode, m_prev, m_s1, m_s2;

  function automatic void model_reset();
    m_mask = '0; m_pend = '0; m_mode = '0; m_prev = '0; m_s1 = '0; m_s2 = '0;
  endfunction

  function automatic int model_cur();
    for (int i = 0; i < NSRC; i++)
      if (m_pend[i] && m_mask[i]) return i;
    return -1;
  endfunction

  // Applies one rising clock edge using the inputs currently driven.
  function automatic void model_clock();
    bit [5:0] ss;
    bit [5:0] np;
    int       id;
    int       reg_sel;
    if (!reset) begin
      model_reset();
      return;
    end
    ss      = SYNC ? m_s2 : src;
    id      = model_cur();
    reg_sel = int'(addr[3:2]);
    np      = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (m_mode[i])                          np[i] = ss[i];
      else if (ss[i] && !m_prev[i])           np[i] = 1'b1;
      else if (we && reg_sel == 1 && din[i])  np[i] = 1'b0;
      else if (int_ack && id == i)            np[i] = 1'b0;
      else                                    np[i] = m_pend[i];
    end
    if (we && reg_sel == 0) m_mask = din[5:0];
    if (we && reg_sel == 2) m_mode = din[5:0];
    m_pend = np;
    for (int i = 0; i < 6; i++) m_prev[i] = (i < NSRC) ? ss[i] : 1'b0;
    m_s2 = m_s1;
    m_s1 = src;
  endfunction

  function automatic logic [31:0] exp_read(int a);
    int id;
    case (a)
      0: return {26'd0, m_mask};
      1: return {26'd0, m_pend};
      2: return {26'd0, m_mode};
      default: begin
        id = model_cur();
        return (id >= 0) ? {1'b1, 28'd0, 3'(id)} : 32'd0;
      end
    endcase
  endfunction

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_clock();
    #1;
  endtask

  task automatic read_const(input int a, input string tag, input logic [31:0] exp);
    addr = 30'(a);
    #1;
    check(tag, dout, exp);
  endtask

  task automatic check_all(input string tag);
    check({tag, "_hwint"}, {26'd0, hwint}, {26'd0, m_pend & m_mask});
    check({tag, "_irq"}, {31'd0, irq}, {31'd0, |(m_pend & m_mask)});
    for (int a = 0; a < 4; a++) begin
      addr = 30'(a);
      #1;
      check($sformatf("%s_rd%0d", tag, a), dout, exp_read(a));
    end
  endtask

  task automatic wr(input int a, input logic [31:0] d);
    addr = 30'(a);
    din  = d;
    we   = 1'b1;
    tick();
    we   = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int unsigned r;
    model_reset();
    reset = 1'b0; addr = '0; we = 1'b0; din = '0; src = 6'h3F; int_ack = 1'b0;

    // Reset held with all sources high: everything reads 0.
    repeat (3) tick();
    for (int a = 0; a < 4; a++) read_const(a, $sformatf("rst_rd%0d", a), 32'd0);
    check("rst_hwint", {26'd0, hwint}, 32'd0);
    src = 6'h00;
    tick();
    reset = 1'b1;
    tick();
    for (int a = 0; a < 4; a++) read_const(a, $sformatf("rel_rd%0d", a), 32'd0);
    check("rel_irq", {31'd0, irq}, 32'd0);

`ifndef IRQC_SYNC_EN
    // Edge latch and W1C.
    wr(0, 32'h03);
    src = 6'h02; tick(); src = 6'h00;
    read_const(1, "t2_pend", 32'h2);
    check("t2_hwint", {26'd0, hwint}, 32'h2);
    read_const(3, "t2_cur", 32'h8000_0001);
    wr(1, 32'h02);
    read_const(1, "t2_pend_clr", 32'h0);
    check("t2_irq", {31'd0, irq}, 32'd0);

    // Priority and acknowledge.
    wr(0, 32'h3F);
    src = 6'h14; tick(); src = 6'h00;
    read_const(3, "t3_cur_a", 32'h8000_0002);
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    read_const(1, "t3_pend", 32'h10);
    read_const(3, "t3_cur_b", 32'h8000_0004);
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    read_const(3, "t3_cur_c", 32'h0);
    // Ack with nothing valid is harmless.
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    check_all("t3_idle_ack");

    // Level mode: W1C and ack have no effect.
    wr(2, 32'h04);
    wr(0, 32'h04);
    src = 6'h04; tick();
    check("t4_hwint", {26'd0, hwint}, 32'h4);
    addr = 30'd1; din = 32'h04; we = 1'b1; int_ack = 1'b1;
    tick();
    we = 1'b0; int_ack = 1'b0;
    check("t4_hwint_held", {26'd0, hwint}, 32'h4);
    src = 6'h00; tick();
    read_const(1, "t4_pend_low", 32'h0);
    wr(2, 32'h00);

    // New edge beats W1C on the same bit; masked source still pending.
    src = 6'h01; addr = 30'd1; din = 32'h01; we = 1'b1;
    tick();
    we = 1'b0;
    read_const(1, "t5_pend", 32'h1);
    wr(0, 32'h00);
    check("t5_irq_masked", {31'd0, irq}, 32'd0);
    read_const(1, "t5_pend_kept", 32'h1);
    src = 6'h00;
    wr(1, 32'h3F);
    check_all("t5_end");

    // Asynchronous reset mid-operation, then release with a source high.
    wr(0, 32'h3F);
    src = 6'h08; tick();
    #2 reset = 1'b0;
    model_reset();
    #1;
    for (int a = 0; a < 4; a++) read_const(a, $sformatf("mid_rd%0d", a), 32'd0);
    check("mid_hwint", {26'd0, hwint}, 32'd0);
    src = 6'h01;
    tick();
    reset = 1'b1;
    tick();
    read_const(1, "rel_high_pend", 32'h1);
    src = 6'h00;
    wr(1, 32'h3F);
`else
    // Synchronizer latency: PEND rises two edges late.
    src = 6'h02;
    tick(); read_const(1, "t6_k",  32'h0);
    tick(); read_const(1, "t6_k1", 32'h0);
    tick(); read_const(1, "t6_k2", 32'h2);
    src = 6'h00;
`endif

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      r       = $urandom();
      src     = src ^ (6'($urandom()) & 6'($urandom()));
      we      = ($urandom_range(0, 3) == 0);
      addr    = {r[27:0], 2'($urandom_range(0, 3))};
      din     = $urandom();
      int_ack = ($urandom_range(0, 3) == 0);
      tick();
      we      = 1'b0;
      int_ack = 1'b0;
      check_all("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
